// File: rtl/note_driver_if.sv
// rtl/note_driver_if.sv - note handshake and sample output bundle for note_driver
// Ports (slave = note_driver side):
//   play                 run enable
//   new_note_valid       note offered
//   note_ready           note accepted when high together with new_note_valid
//   note_step            20-bit phase increment per sample
//   note_duration_in     6-bit note length in beats
//   note_duration        latched duration of the current note
//   generate_next_sample one-cycle sample strobe
//   sample               signed 16-bit square-wave sample
//   done_with_note       one-cycle end-of-note pulse
//   busy                 note in progress
interface note_driver_if;
  logic               play;
  logic               new_note_valid;
  logic               note_ready;
  logic [19:0]        note_step;
  logic [5:0]         note_duration_in;
  logic [5:0]         note_duration;
  logic               generate_next_sample;
  logic signed [15:0] sample;
  logic               done_with_note;
  logic               busy;

  modport slave (
    input  play, new_note_valid, note_step, note_duration_in,
    output note_ready, note_duration, generate_next_sample, sample,
           done_with_note, busy
  );

  modport master (
    output play, new_note_valid, note_step, note_duration_in,
    input  note_ready, note_duration, generate_next_sample, sample,
           done_with_note, busy
  );
endinterface

// File: rtl/note_driver.sv
// rtl/note_driver.sv - square-wave note source pacing the sample strobe and note duration
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    note_driver_if.slave (handshake, note fields, sample outputs)
// Optional feature: NOTE_DRIVER_REST_EN makes note_step==0 a silent rest.
module note_driver #(
  parameter int                 SAMPLE_DIV = 1136,
  parameter int                 BEAT_DIV   = 4,
  parameter logic signed [15:0] AMPLITUDE  = 16'sh3FFF
) (
  input  logic          clk,
  input  logic          reset,
  note_driver_if.slave  bus
);

  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int BW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);

  typedef enum logic [1:0] {IDLE, PLAYING, DONE} state_t;

  state_t state, state_n;

  logic [19:0]        step_q;
  logic [19:0]        phase;
  logic [DW-1:0]      div_cnt;
  logic [BW-1:0]      beat_cnt;
  logic [5:0]         remaining;
  logic [5:0]         duration_q;
  logic signed [15:0] sample_q;

  logic               transfer;
  logic               strobe;
  logic               done_pulse;
  logic               ready;
  logic               busy_c;
  logic [19:0]        phase_n;

  assign phase_n = phase + step_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // play only gates the PLAYING/DONE progress; a note offered in IDLE is
  // still taken, it just will not advance until play returns.
  always_comb begin
    state_n    = state;
    ready      = 1'b0;
    busy_c     = 1'b0;
    transfer   = 1'b0;
    strobe     = 1'b0;
    done_pulse = 1'b0;
    case (state)
      IDLE: begin
        ready    = 1'b1;
        transfer = bus.new_note_valid;
        if (bus.new_note_valid)
          state_n = (bus.note_duration_in != 6'd0) ? PLAYING : DONE;
      end
      PLAYING: begin
        busy_c = 1'b1;
        if (bus.play && div_cnt == DIV_LAST) begin
          strobe = 1'b1;
          if (beat_cnt == BEAT_LAST && remaining == 6'd1)
            state_n = DONE;
        end
      end
      DONE: begin
        busy_c = 1'b1;
        if (bus.play) begin
          done_pulse = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q     <= '0;
      phase      <= '0;
      div_cnt    <= '0;
      beat_cnt   <= '0;
      remaining  <= '0;
      duration_q <= '0;
      sample_q   <= '0;
    end else begin
      if (transfer) begin
        step_q     <= bus.note_step;
        duration_q <= bus.note_duration_in;
        remaining  <= bus.note_duration_in;
        phase      <= '0;
        div_cnt    <= '0;
        beat_cnt   <= '0;
      end else if (state == PLAYING && bus.play) begin
        if (strobe) begin
          div_cnt <= '0;
          phase   <= phase_n;
`ifdef NOTE_DRIVER_REST_EN
          if (step_q == 20'd0)
            sample_q <= '0;
          else
            sample_q <= phase_n[19] ? -AMPLITUDE : AMPLITUDE;
`else
          sample_q <= phase_n[19] ? -AMPLITUDE : AMPLITUDE;
`endif
          if (beat_cnt == BEAT_LAST) begin
            beat_cnt  <= '0;
            remaining <= remaining - 6'd1;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else if (done_pulse) begin
        sample_q <= '0;
        phase    <= '0;
      end
    end
  end

  assign bus.note_ready           = ready;
  assign bus.busy                 = busy_c;
  assign bus.generate_next_sample = strobe;
  assign bus.done_with_note       = done_pulse;
  assign bus.sample               = sample_q;
  assign bus.note_duration        = duration_q;

endmodule

// File: tb/tb_note_driver.sv
// tb/tb_note_driver.sv - self-checking bench for note_driver
module tb_note_driver;

  localparam int SD = 4;
  localparam int BD = 2;
  localparam logic signed [15:0] AMP = 16'sh3FFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  note_driver_if bus();

  note_driver #(.SAMPLE_DIV(SD), .BEAT_DIV(BD), .AMPLITUDE(AMP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample after the n-th strobe: phase is n*step mod 2^20, sign from its top bit.
  function automatic logic signed [15:0] model_sample(input logic [19:0] step, input int n);
    longint ph;
    if (n == 0) return 16'sd0;
`ifdef NOTE_DRIVER_REST_EN
    if (step == 20'd0) return 16'sd0;
`endif
    ph = (longint'(step) * longint'(n)) & 64'hFFFFF;
    return ph[19] ? -AMP : AMP;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 32'(bus.note_ready), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_sample"}, {16'h0, bus.sample}, 32'h0);
    chk({tag, "_strobe"}, 32'(bus.generate_next_sample), 32'd0);
    chk({tag, "_done"}, 32'(bus.done_with_note), 32'd0);
  endtask

  // Called at a negedge; transfers on the next posedge and follows the note.
  task automatic play_note(input logic [19:0] step, input logic [5:0] dur,
                           input int pause_at, input int pause_len, input int abort_at,
                           input bit hold, input logic [19:0] hstep, input logic [5:0] hdur);
    int n_str;
    int strobes;
    int cyc;
    int n;
    logic signed [15:0] exp_s;
    logic signed [15:0] held;
    n_str   = int'(dur) * BD;
    strobes = 0;
    cyc     = 0;
    bus.new_note_valid   = 1'b1;
    bus.note_step        = step;
    bus.note_duration_in = dur;
    @(posedge clk);
    for (int k = 0; k <= n_str * SD + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (hold) begin
          bus.note_step        = hstep;
          bus.note_duration_in = hdur;
        end else begin
          bus.new_note_valid = 1'b0;
        end
      end
      #1;
      if (k == n_str * SD + 1) begin
        check_idle("after_done");
        chk("strobe_count", 32'(strobes), 32'(n_str));
        break;
      end
      chk("strobe", 32'(bus.generate_next_sample), 32'(((k + 1) % SD == 0) && (k < n_str * SD)));
      chk("done", 32'(bus.done_with_note), 32'(k == n_str * SD));
      chk("ready_low", 32'(bus.note_ready), 32'd0);
      chk("busy", 32'(bus.busy), 32'd1);
      chk("note_duration", 32'(bus.note_duration), 32'(dur));
      n = (k < SD) ? 0 : ((k / SD > n_str) ? n_str : k / SD);
      exp_s = model_sample(step, n);
      chk("sample", {16'h0, bus.sample}, {16'h0, exp_s});
      if (bus.generate_next_sample) strobes++;
      if (k == n_str * SD)
        chk("done_latency", 32'(cyc), 32'(n_str * SD + ((pause_at >= 0) ? pause_len : 0)));
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        check_idle("reset_async");
        chk("reset_dur", 32'(bus.note_duration), 32'd0);
        @(negedge clk);
        check_idle("reset_hold");
        reset = 1'b0;
        bus.new_note_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check_idle("after_reset");
        end
        return;
      end
      if (k == pause_at) begin
        held = bus.sample;
        bus.play = 1'b0;
        for (int j = 0; j < pause_len; j++) begin
          @(negedge clk);
          cyc++;
          #1;
          chk("pause_strobe", 32'(bus.generate_next_sample), 32'd0);
          chk("pause_done", 32'(bus.done_with_note), 32'd0);
          chk("pause_sample", {16'h0, bus.sample}, {16'h0, held});
          chk("pause_busy", 32'(bus.busy), 32'd1);
        end
        bus.play = 1'b1;
      end
      cyc++;
    end
  endtask

  initial begin
    logic [19:0] rs;
    logic [5:0]  rd;
    bus.play             = 1'b1;
    bus.new_note_valid   = 1'b0;
    bus.note_step        = '0;
    bus.note_duration_in = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    chk("reset_dur", 32'(bus.note_duration), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Quarter-turn step: +,-,-,+,+,- over six strobes.
    play_note(20'h40000, 6'd3, -1, 0, -1, 1'b0, '0, '0);
    // Zero-duration note.
    play_note(20'h12345, 6'd0, -1, 0, -1, 1'b0, '0, '0);
    // Offer a different note throughout; it must land the moment ready returns.
    play_note(20'h30000, 6'd2, -1, 0, -1, 1'b1, 20'h0A000, 6'd1);
    play_note(20'h0A000, 6'd1, -1, 0, -1, 1'b0, '0, '0);
    // Pause for 10 cycles mid-note.
    play_note(20'h40000, 6'd3, 9, 10, -1, 1'b0, '0, '0);
    // Reset during the third strobe, then a clean note.
    play_note(20'h40000, 6'd3, -1, 0, 3 * SD - 1, 1'b0, '0, '0);
    play_note(20'h40000, 6'd3, -1, 0, -1, 1'b0, '0, '0);
    // Zero step: rest or DC depending on the build.
    play_note(20'h00000, 6'd1, -1, 0, -1, 1'b0, '0, '0);
    // Random notes.
    for (int i = 0; i < 6; i++) begin
      rs = 20'($urandom);
      rd = 6'($urandom_range(1, 4));
      play_note(rs, rd, -1, 0, -1, 1'b0, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
